// File: rtl/vector_scanner.sv
// vector_scanner: takes a WIDTH-bit vector over valid/ready and reports set-bit
// indices, either the first one only or every one in turn, on a registered output.
module vector_scanner #(
  parameter int  WIDTH     = 32,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int POS_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [POS_W-1:0] out_pos_o,
  output logic             out_last_o,
  output logic             out_none_o
);

  localparam int LOG = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               mode_q, mode_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               last_q, last_d;
  logic               none_q, none_d;

  logic               accept;
  logic               outFire;
  logic [WIDTH-1:0]   clearMask;
  logic [WIDTH-1:0]   remaining;
  logic [WIDTH-1:0]   scanSrc;
  logic [WIDTH-1:0]   scanOrdered;
  logic               scanSingle;
  logic               foundAny;
  logic [LOG-1:0]     rawIdx;
  logic [LOG-1:0]     mappedIdx;
  logic [POS_W-1:0]   scanPos;

  assign in_ready_o  = (state_q == IDLE) || (out_ready_i && last_q);
  assign accept      = in_valid_i && in_ready_o;
  assign outFire     = (state_q == EMIT) && out_ready_i;

  assign clearMask   = {{(WIDTH-1){1'b0}}, 1'b1} << pos_q[LOG-1:0];
  assign remaining   = work_q & ~clearMask;

  // One search tree serves both a freshly accepted vector and the leftover bits.
  assign scanSrc     = accept ? in_data_i : remaining;
  assign scanSingle  = (scanSrc != '0) && ((scanSrc & (scanSrc - WIDTH'(1))) == '0);

  // Reversing the input lets one lowest-first tree serve both directions.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      scanOrdered[i] = MSB_FIRST ? scanSrc[WIDTH-1-i] : scanSrc[i];
    end
  end

  for (genvar l = 0; l <= LOG; l++) begin : lvl
    localparam int N = WIDTH >> l;
    logic [N-1:0]     v;
    logic [N*LOG-1:0] ix;
    if (l == 0) begin : leaf
      assign v  = scanOrdered;
      assign ix = '0;
    end else begin : node
      for (genvar n = 0; n < N; n++) begin : pair
        logic [LOG-1:0] lowIdx;
        logic [LOG-1:0] highIdx;
        assign lowIdx  = lvl[l-1].ix[(2*n)*LOG +: LOG];
        assign highIdx = lvl[l-1].ix[(2*n+1)*LOG +: LOG] | (LOG'(1) << (l-1));
        assign v[n]    = lvl[l-1].v[2*n] | lvl[l-1].v[2*n+1];
        assign ix[n*LOG +: LOG] = lvl[l-1].v[2*n] ? lowIdx : highIdx;
      end
    end
  end

  assign foundAny  = lvl[LOG].v[0];
  assign rawIdx    = lvl[LOG].ix[LOG-1:0];
  assign mappedIdx = MSB_FIRST ? ~rawIdx : rawIdx;
  assign scanPos   = foundAny ? {1'b0, mappedIdx} : POS_W'(WIDTH);

  // An accept always wins, which lets a new vector follow the last result with no bubble.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    last_d  = last_q;
    none_d  = none_q;
    if (accept) begin
      state_d = EMIT;
      work_d  = in_data_i;
      mode_d  = in_mode_i;
      pos_d   = scanPos;
      none_d  = !foundAny;
      last_d  = !foundAny || !in_mode_i || scanSingle;
    end else if (outFire) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        work_d = remaining;
        pos_d  = scanPos;
        last_d = !mode_q || scanSingle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      pos_q   <= '0;
      last_q  <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      none_q  <= none_d;
    end
  end

  assign out_valid_o = (state_q == EMIT);
  assign out_pos_o   = pos_q;
  assign out_last_o  = last_q;
  assign out_none_o  = none_q;

endmodule
